ioctl_sdram_loader: RTL

Converts the HPS ioctl byte stream into 16-bit SDRAM write requests for the Bocks core. It sits inside `bocks_top`, between the ioctl download port (`ioctl_wr`/`ioctl_addr`/`ioctl_dout`/`ioctl_wait`) and the SDRAM controller's write port. It packs byte pairs into words, buffers them in a small FIFO, and back-pressures the HPS with `ioctl_wait`. When a download ends it flushes any dangling byte and raises `done`.

---
 rtl/ioctl_sdram_loader.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/ioctl_sdram_loader.sv
// Packs the HPS ioctl byte stream into 16-bit SDRAM write requests through a small word FIFO.
// Optional running byte checksum port when LOADER_CHECKSUM_EN is defined.
module ioctl_sdram_loader #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned BASE_WORD  = 0
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [26:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        ram_req,
    output logic [25:0] ram_addr,
    output logic [15:0] ram_data,
    output logic [1:0]  ram_be,
    input  logic        ram_ack,
    output logic        busy,
    output logic        done
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [15:0] checksum
`endif
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [25:0] BaseWord = 26'(BASE_WORD);

    typedef struct packed {
        logic [25:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
    } entry_t;

    typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDone} state_t;

    state_t             state_q, state_d;
    logic               dl_q;
    logic               wait_q;
    logic               pend_v_q, pend_v_d;
    logic [26:0]        pend_addr_q, pend_addr_d;
    logic [7:0]         pend_data_q, pend_data_d;
    logic               spill_v_q, spill_v_d;
    entry_t             spill_q, spill_d;
    entry_t             mem [FIFO_DEPTH];
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]    count_q, count_d;
    logic [CntW-1:0]    free_slots;

    logic               arrival, rise, fall, pairs, pop, drained;
    logic [25:0]        byte_word, pend_word;
    entry_t             pend_entry, odd_entry, pair_entry;
    entry_t             push_a, push_b;
    logic               push_a_v, push_b_v;
    entry_t             item0, item1, item2, head;
    logic [1:0]         n_items, allowed, lanes;

    assign arrival   = ioctl_wr & ioctl_download;
    assign rise      = ioctl_download & ~dl_q;
    assign fall      = ~ioctl_download & dl_q;
    assign byte_word = ioctl_addr[26:1] + BaseWord;
    assign pend_word = pend_addr_q[26:1] + BaseWord;
    assign pairs     = ioctl_addr[0] & pend_v_q & (ioctl_addr == pend_addr_q + 27'd1);

    assign pend_entry = '{addr: pend_word, data: {8'h00, pend_data_q}, be: 2'b01};
    assign odd_entry  = '{addr: byte_word, data: {ioctl_dout, 8'h00}, be: 2'b10};
    assign pair_entry = '{addr: byte_word, data: {ioctl_dout, pend_data_q}, be: 2'b11};

    // Byte pairing: yields up to two ordered pushes per cycle (push_a before push_b).
    always_comb begin
        push_a_v    = 1'b0;
        push_a      = '0;
        push_b_v    = 1'b0;
        push_b      = '0;
        pend_v_d    = pend_v_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        if (arrival) begin
            if (pairs) begin
                push_a_v = 1'b1;
                push_a   = pair_entry;
                pend_v_d = 1'b0;
            end else if (!ioctl_addr[0]) begin
                push_a_v    = pend_v_q;
                push_a      = pend_entry;
                pend_v_d    = 1'b1;
                pend_addr_d = ioctl_addr;
                pend_data_d = ioctl_dout;
            end else begin
                if (pend_v_q) begin
                    push_a_v = 1'b1;
                    push_a   = pend_entry;
                    push_b_v = 1'b1;
                    push_b   = odd_entry;
                end else begin
                    push_a_v = 1'b1;
                    push_a   = odd_entry;
                end
                pend_v_d = 1'b0;
            end
        end else if (fall && pend_v_q) begin
            push_a_v = 1'b1;
            push_a   = pend_entry;
            pend_v_d = 1'b0;
        end
    end

    // Spill drains first so it stays ahead of newer pushes; only then may two lanes write.
    always_comb begin
        item0      = spill_v_q ? spill_q : push_a;
        item1      = spill_v_q ? push_a : push_b;
        item2      = push_b;
        n_items    = {1'b0, spill_v_q} + {1'b0, push_a_v} + {1'b0, push_b_v};
        allowed    = spill_v_q ? 2'd2 : 2'd1;
        free_slots = CntW'(FIFO_DEPTH) - count_q;
        lanes      = n_items;
        if (lanes > allowed) begin
            lanes = allowed;
        end
        if (CntW'(lanes) > free_slots) begin
            lanes = free_slots[1:0];
        end
        spill_v_d = (n_items != lanes);
        unique case (lanes)
            2'd0:    spill_d = item0;
            2'd1:    spill_d = item1;
            default: spill_d = item2;
        endcase
        pop      = ram_ack & (count_q != '0);
        count_d  = count_q + CntW'(lanes) - CntW'(pop);
        wr_ptr_d = wr_ptr_q + PtrW'(lanes);
        rd_ptr_d = rd_ptr_q + PtrW'(pop);
    end

    assign drained = !pend_v_d && !spill_v_d && (count_d == '0);

    always_comb begin
        state_d = state_q;
        if (rise) begin
            state_d = StLoad;
        end else begin
            case (state_q)
                StIdle:  state_d = StIdle;
                StLoad:  if (fall) state_d = StFlush;
                StFlush: if (drained) state_d = StDone;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= StIdle;
            dl_q        <= 1'b0;
            wait_q      <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            spill_v_q   <= 1'b0;
            spill_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            dl_q        <= ioctl_download;
            wait_q      <= ((CntW'(FIFO_DEPTH) - count_d) <= CntW'(2)) | spill_v_d;
            pend_v_q    <= pend_v_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            spill_v_q   <= spill_v_d;
            spill_q     <= spill_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            if (lanes != 2'd0) begin
                mem[wr_ptr_q] <= item0;
            end
            if (lanes == 2'd2) begin
                mem[wr_ptr_q + PtrW'(1)] <= item1;
            end
        end
    end

    assign head       = mem[rd_ptr_q];
    assign ram_req    = (count_q != '0);
    assign ram_addr   = ram_req ? head.addr : '0;
    assign ram_data   = ram_req ? head.data : '0;
    assign ram_be     = ram_req ? head.be : '0;
    assign ioctl_wait = wait_q;
    assign busy       = ram_req | spill_v_q | pend_v_q;
    assign done       = (state_q == StDone);

`ifdef LOADER_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (rise) begin
            csum_d = '0;
        end
        if (arrival) begin
            csum_d = csum_d + {8'h00, ioctl_dout};
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`endif

endmodule
